acc_burst_arbiter: RTL and testbench
====================================

Name: acc_burst_arbiter

Overview:
- Round-robin controller that shares one 32-bit accumulator datapath between two requester streams.
- Per grant: forwards exactly cfg_len beats as one contiguous valid burst, captures the accumulator sum one cycle after the last beat, and holds it as a result.
- Raises a one-cycle interrupt per result; result is held until software acks.
- Sits between PS-side stream sources and the accumulator.

Parameters:
- DATA_W, 32, width of requester data, accumulator data and result.
- LEN_W, 8, width of burst-length config and internal beat counter.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-low reset
- i_cfg_len  in  LEN_W  beats per burst; sampled at grant
- i_req0_valid  in  1  requester 0 beat valid
- i_req0_data  in  DATA_W  requester 0 beat data
- o_req0_ready  out  1  requester 0 beat accepted when valid&ready
- i_req1_valid  in  1  requester 1 beat valid
- i_req1_data  in  DATA_W  requester 1 beat data
- o_req1_ready  out  1  requester 1 beat accepted when valid&ready
- o_acc_data  out  DATA_W  beat to accumulator
- o_acc_valid  out  1  beat valid to accumulator; low clears accumulator
- i_acc_data  in  DATA_W  accumulator running sum
- i_acc_valid  in  1  accumulator sum valid
- o_result  out  DATA_W  captured burst sum
- o_result_src  out  1  requester that produced o_result
- o_result_valid  out  1  result held
- i_result_ack  in  1  result consumed
- o_intr  out  1  one-cycle pulse on result capture
- o_err  out  1  one-cycle pulse on burst abort (or mismatch, see option)
- o_busy  out  1  state != IDLE

Behaviour:
- Clock and reset:
  - One clock, i_clk. Reset i_rst is asynchronous, active-low.
  - Reset values: all outputs 0, state IDLE, beat count 0, round-robin pointer = 1 (requester 0 wins first).
- States: IDLE -> RUN -> CAPT -> DONE -> IDLE. RUN can also exit to IDLE via abort.
- IDLE:
  - If i_cfg_len == 0, stay IDLE and ignore requests.
  - Otherwise, if any i_reqN_valid, grant the requester after the pointer; if only one is valid, grant it.
  - Latch the grant and i_cfg_len, clear count, go to RUN next cycle. Readies are 0 in IDLE.
- RUN:
  - o_reqG_ready = 1 while count < len (combinational from state/count). Other ready = 0.
  - Each accepted beat: next cycle o_acc_valid = 1, o_acc_data = beat, count++.
  - Beats must be back-to-back. First-beat wait is allowed with no error.
  - If count is in [1, len-1] and i_reqG_valid = 0: abort.
    - o_acc_valid = 0 next cycle.
    - o_err pulses.
    - Flip the pointer to G and go to IDLE. No result, no o_intr.
  - When count reaches len: ready drops and the state goes to CAPT.
- CAPT:
  - o_acc_valid = 0 (last beat was presented in the previous cycle).
  - Sample i_acc_data when i_acc_valid = 1. The accumulator registers the sum one cycle after the last beat.
  - o_result <= sum, o_result_src <= G, o_result_valid <= 1, o_intr pulses 1 cycle, pointer <= G. Go to DONE.
  - If i_acc_valid = 0 in CAPT: o_err pulses, no result, go to IDLE.
- DONE:
  - Hold o_result, o_result_src and o_result_valid until i_result_ack = 1.
  - On ack: o_result_valid <= 0 next cycle, go to IDLE. Ack outside DONE is ignored.
- Inter-burst gap: at least 1 IDLE cycle with o_acc_valid = 0 guarantees the accumulator restarts from 0.
- Latency: result_valid rises len+3 cycles after the grant cycle for an unstalled burst.
- Arithmetic: sum is modulo 2^DATA_W, inherited from the accumulator. The controller never adds in base config.
- Non-granted requester is never accepted while the other is granted.
- Mid-operation changes: i_cfg_len changes after grant are ignored.
- Asynchronous reset mid-burst returns to IDLE immediately. All outputs go to reset values, including o_acc_valid = 0.

Optional Feature:
- Macro: ACC_RESULT_CHECK_EN.
- Defined:
  - Controller keeps a DATA_W shadow sum (cleared at grant, adds each accepted beat, modulo 2^DATA_W).
  - In CAPT, if i_acc_data != shadow, o_err pulses alongside o_intr.
  - The result is still captured from i_acc_data.
- Not defined: no shadow logic; o_err only on abort or missing i_acc_valid.

Test Plan:
- cfg_len=4, req0 sends 1,2,3,4 back-to-back, req1 idle -> o_result=10, o_result_src=0, o_intr one pulse, result_valid 7 cycles after grant; ack -> result_valid=0, IDLE.
- Both valid from reset, cfg_len=2, req0={5,6}, req1={7,8}, ack each result -> results 11 (src 0), then 15 (src 1), alternating; req1 ready never high during req0 burst.
- cfg_len=3, req1 sends 9, then valid low 1 cycle -> o_err pulse, o_acc_valid low next cycle, no o_intr; next burst req1 {1,1,1} -> result 3, proving accumulator restarted at 0.
- cfg_len=2, beats 0xFFFFFFFF and 0x00000002 -> o_result=0x00000001 (wrap).
- cfg_len=0 with both requesters valid for 20 cycles -> readies stay 0, o_busy=0; assert i_rst low mid-RUN -> all outputs 0 asynchronously, state IDLE.
- ACC_RESULT_CHECK_EN: force i_acc_data=0x1234 in CAPT for a burst {1,1} -> o_result=0x1234, o_err and o_intr pulse together.

Source files
------------

// File: rtl/acc_burst_arbiter_if.sv
// Signal bundle between the stream sources, acc_burst_arbiter and the accumulator.
// slave: the arbiter's view; master: the surrounding system's view.
interface acc_burst_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
);
   logic [LEN_W-1:0]  i_cfg_len;
   logic              i_req0_valid;
   logic [DATA_W-1:0] i_req0_data;
   logic              o_req0_ready;
   logic              i_req1_valid;
   logic [DATA_W-1:0] i_req1_data;
   logic              o_req1_ready;
   logic [DATA_W-1:0] o_acc_data;
   logic              o_acc_valid;
   logic [DATA_W-1:0] i_acc_data;
   logic              i_acc_valid;
   logic [DATA_W-1:0] o_result;
   logic              o_result_src;
   logic              o_result_valid;
   logic              i_result_ack;
   logic              o_intr;
   logic              o_err;
   logic              o_busy;
   logic [1:0]        o_dbg_state;

   modport slave (
      input  i_cfg_len,
      input  i_req0_valid, i_req0_data,
      output o_req0_ready,
      input  i_req1_valid, i_req1_data,
      output o_req1_ready,
      output o_acc_data, o_acc_valid,
      input  i_acc_data, i_acc_valid,
      output o_result, o_result_src, o_result_valid,
      input  i_result_ack,
      output o_intr, o_err, o_busy, o_dbg_state
   );

   modport master (
      output i_cfg_len,
      output i_req0_valid, i_req0_data,
      input  o_req0_ready,
      output i_req1_valid, i_req1_data,
      input  o_req1_ready,
      input  o_acc_data, o_acc_valid,
      output i_acc_data, i_acc_valid,
      input  o_result, o_result_src, o_result_valid,
      output i_result_ack,
      input  o_intr, o_err, o_busy, o_dbg_state
   );
endinterface

// File: rtl/acc_burst_arbiter.sv
// Round-robin burst arbiter feeding one accumulator from two requester streams.
// Optional macro ACC_RESULT_CHECK_EN adds a shadow sum that flags accumulator mismatches.
module acc_burst_arbiter #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input logic                i_clk,
   input logic                i_rst,
   acc_burst_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CAPT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic              ptr_q, ptr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              acc_valid_q, acc_valid_d;
   logic [DATA_W-1:0] acc_data_q, acc_data_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              src_q, src_d;
   logic              rvalid_q, rvalid_d;
   logic              intr_q, intr_d;
   logic              err_q, err_d;

   logic              run_open;
   logic              g_valid;
   logic [DATA_W-1:0] g_data;
   logic              arb_sel;
   logic              beat_accept;
   logic              chk_mismatch;

   // Handshake: a beat transfers on a cycle where reqN_valid and reqN_ready are both
   // high; ready depends only on state/count, never on valid, and only the granted side opens.
   assign run_open     = (state_q == RUN) && (cnt_q < len_q);
   assign g_valid      = grant_q ? bus.i_req1_valid : bus.i_req0_valid;
   assign g_data       = grant_q ? bus.i_req1_data  : bus.i_req0_data;
   assign beat_accept  = run_open && g_valid;
   assign arb_sel      = (bus.i_req0_valid && bus.i_req1_valid) ? ~ptr_q : bus.i_req1_valid;

`ifdef ACC_RESULT_CHECK_EN
   logic [DATA_W-1:0] shadow_q;

   // Cleared throughout IDLE so every granted burst starts from zero.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         shadow_q <= '0;
      end else if (state_q == IDLE) begin
         shadow_q <= '0;
      end else if (beat_accept) begin
         shadow_q <= shadow_q + g_data;
      end
   end

   assign chk_mismatch = (bus.i_acc_data != shadow_q);
`else
   assign chk_mismatch = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= IDLE;
         grant_q     <= 1'b0;
         ptr_q       <= 1'b1;
         len_q       <= '0;
         cnt_q       <= '0;
         acc_valid_q <= 1'b0;
         acc_data_q  <= '0;
         result_q    <= '0;
         src_q       <= 1'b0;
         rvalid_q    <= 1'b0;
         intr_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ptr_q       <= ptr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         acc_valid_q <= acc_valid_d;
         acc_data_q  <= acc_data_d;
         result_q    <= result_d;
         src_q       <= src_d;
         rvalid_q    <= rvalid_d;
         intr_q      <= intr_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      acc_valid_d = 1'b0;
      acc_data_d  = acc_data_q;
      result_d    = result_q;
      src_d       = src_q;
      rvalid_d    = rvalid_q;
      intr_d      = 1'b0;
      err_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if ((bus.i_cfg_len != '0) && (bus.i_req0_valid || bus.i_req1_valid)) begin
               grant_d = arb_sel;
               len_d   = bus.i_cfg_len;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (beat_accept) begin
               acc_valid_d = 1'b1;
               acc_data_d  = g_data;
               cnt_d       = cnt_q + 1'b1;
            end else if (cnt_q == len_q) begin
               state_d = CAPT;
            end else if (cnt_q != '0) begin
               // A gap after the first beat breaks the contiguous burst.
               err_d   = 1'b1;
               ptr_d   = grant_q;
               state_d = IDLE;
            end
         end
         CAPT: begin
            if (bus.i_acc_valid) begin
               result_d = bus.i_acc_data;
               src_d    = grant_q;
               rvalid_d = 1'b1;
               intr_d   = 1'b1;
               err_d    = chk_mismatch;
               ptr_d    = grant_q;
               state_d  = DONE;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         DONE: begin
            if (bus.i_result_ack) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.o_req0_ready   = run_open && !grant_q;
   assign bus.o_req1_ready   = run_open && grant_q;
   assign bus.o_acc_valid    = acc_valid_q;
   assign bus.o_acc_data     = acc_data_q;
   assign bus.o_result       = result_q;
   assign bus.o_result_src   = src_q;
   assign bus.o_result_valid = rvalid_q;
   assign bus.o_intr         = intr_q;
   assign bus.o_err          = err_q;
   assign bus.o_busy         = (state_q != IDLE);
   assign bus.o_dbg_state    = state_q;

endmodule

// File: tb/tb_acc_burst_arbiter.sv
// Directed bench for acc_burst_arbiter with a behavioural accumulator model.
module tb_acc_burst_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic        force_en  = 1'b0;
   logic [31:0] force_val = 32'd0;
   logic [31:0] acc_sum;
   logic        acc_vld;
   logic        exp_chk_err;

   always #5 clk = ~clk;

   acc_burst_arbiter_if #(.DATA_W(32), .LEN_W(8)) bus ();

   acc_burst_arbiter #(.DATA_W(32), .LEN_W(8)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Accumulator: sums while o_acc_valid is high, clears when it is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_sum <= 32'd0;
         acc_vld <= 1'b0;
      end else begin
         acc_vld <= bus.o_acc_valid;
         acc_sum <= bus.o_acc_valid ? acc_sum + bus.o_acc_data : 32'd0;
      end
   end

   assign bus.i_acc_data  = force_en ? force_val : acc_sum;
   assign bus.i_acc_valid = acc_vld;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef ACC_RESULT_CHECK_EN
      exp_chk_err = 1'b1;
`else
      exp_chk_err = 1'b0;
`endif
      bus.i_cfg_len    = 8'd0;
      bus.i_req0_valid = 1'b0;
      bus.i_req0_data  = 32'd0;
      bus.i_req1_valid = 1'b0;
      bus.i_req1_data  = 32'd0;
      bus.i_result_ack = 1'b0;

      // Reset values
      tick();
      tick();
      chk1("rst_acc_valid", bus.o_acc_valid, 1'b0);
      chk1("rst_busy", bus.o_busy, 1'b0);
      chk1("rst_rvalid", bus.o_result_valid, 1'b0);
      chk("rst_state", 32'(bus.o_dbg_state), 32'd0);
      rst = 1'b1;
      tick();
      chk1("idle_r0", bus.o_req0_ready, 1'b0);

      // Burst of 4 from req0: 1+2+3+4 = 10, result 7 cycles after grant
      bus.i_cfg_len    = 8'd4;
      bus.i_req0_valid = 1'b1;
      bus.i_req0_data  = 32'd1;
      tick();
      chk1("t1_r0", bus.o_req0_ready, 1'b1);
      chk1("t1_r1", bus.o_req1_ready, 1'b0);
      chk1("t1_busy", bus.o_busy, 1'b1);
      for (int b = 2; b <= 4; b++) begin
         tick();
         chk1("t1_beat_valid", bus.o_acc_valid, 1'b1);
         chk("t1_beat_data", bus.o_acc_data, 32'(b - 1));
         chk1("t1_r0_open", bus.o_req0_ready, 1'b1);
         bus.i_req0_data = 32'(b);
      end
      tick();
      chk("t1_last_data", bus.o_acc_data, 32'd4);
      chk1("t1_r0_closed", bus.o_req0_ready, 1'b0);
      bus.i_req0_valid = 1'b0;
      tick();
      chk1("t1_capt_acc_valid", bus.o_acc_valid, 1'b0);
      chk1("t1_rvalid_early", bus.o_result_valid, 1'b0);
      tick();
      chk1("t1_rvalid", bus.o_result_valid, 1'b1);
      chk("t1_result", bus.o_result, 32'd10);
      chk1("t1_src", bus.o_result_src, 1'b0);
      chk1("t1_intr", bus.o_intr, 1'b1);
      chk1("t1_err", bus.o_err, 1'b0);
      tick();
      chk1("t1_intr_pulse", bus.o_intr, 1'b0);
      chk1("t1_rvalid_hold", bus.o_result_valid, 1'b1);
      bus.i_result_ack = 1'b1;
      tick();
      chk1("t1_ack_rvalid", bus.o_result_valid, 1'b0);
      chk1("t1_ack_busy", bus.o_busy, 1'b0);
      bus.i_result_ack = 1'b0;

      // Both requesters from reset, len 2: 5+6 = 11 (src 0), then 7+8 = 15 (src 1)
      rst = 1'b0;
      tick();
      rst = 1'b1;
      bus.i_cfg_len    = 8'd2;
      bus.i_req0_valid = 1'b1;
      bus.i_req0_data  = 32'd5;
      bus.i_req1_valid = 1'b1;
      bus.i_req1_data  = 32'd7;
      tick();
      chk1("t2_r0", bus.o_req0_ready, 1'b1);
      chk1("t2_r1_a", bus.o_req1_ready, 1'b0);
      tick();
      chk("t2_b0", bus.o_acc_data, 32'd5);
      chk1("t2_r1_b", bus.o_req1_ready, 1'b0);
      bus.i_req0_data = 32'd6;
      tick();
      chk("t2_b1", bus.o_acc_data, 32'd6);
      chk1("t2_r1_c", bus.o_req1_ready, 1'b0);
      bus.i_req0_valid = 1'b0;
      tick();
      chk1("t2_r1_d", bus.o_req1_ready, 1'b0);
      tick();
      chk("t2_result0", bus.o_result, 32'd11);
      chk1("t2_src0", bus.o_result_src, 1'b0);
      chk1("t2_intr0", bus.o_intr, 1'b1);
      bus.i_result_ack = 1'b1;
      tick();
      chk1("t2_ack0", bus.o_result_valid, 1'b0);
      bus.i_result_ack = 1'b0;
      tick();
      chk1("t2_r1_grant", bus.o_req1_ready, 1'b1);
      chk1("t2_r0_shut", bus.o_req0_ready, 1'b0);
      tick();
      chk("t2_b2", bus.o_acc_data, 32'd7);
      bus.i_req1_data = 32'd8;
      tick();
      chk("t2_b3", bus.o_acc_data, 32'd8);
      bus.i_req1_valid = 1'b0;
      tick();
      tick();
      chk("t2_result1", bus.o_result, 32'd15);
      chk1("t2_src1", bus.o_result_src, 1'b1);
      chk1("t2_intr1", bus.o_intr, 1'b1);
      bus.i_result_ack = 1'b1;
      tick();
      chk1("t2_ack1", bus.o_result_valid, 1'b0);
      bus.i_result_ack = 1'b0;

      // Abort on a mid-burst gap, then a clean burst proves the accumulator restarted
      bus.i_cfg_len    = 8'd3;
      bus.i_req1_valid = 1'b1;
      bus.i_req1_data  = 32'd9;
      tick();
      tick();
      chk("t3_b0", bus.o_acc_data, 32'd9);
      bus.i_req1_valid = 1'b0;
      tick();
      chk1("t3_err", bus.o_err, 1'b1);
      chk1("t3_acc_valid", bus.o_acc_valid, 1'b0);
      chk1("t3_intr", bus.o_intr, 1'b0);
      chk1("t3_busy", bus.o_busy, 1'b0);
      bus.i_req1_valid = 1'b1;
      bus.i_req1_data  = 32'd1;
      tick();
      chk1("t3_err_pulse", bus.o_err, 1'b0);
      chk1("t3_intr_b", bus.o_intr, 1'b0);
      for (int b = 0; b < 3; b++) begin
         tick();
         chk("t3_beat", bus.o_acc_data, 32'd1);
      end
      bus.i_req1_valid = 1'b0;
      tick();
      tick();
      chk("t3_result", bus.o_result, 32'd3);
      chk1("t3_src", bus.o_result_src, 1'b1);
      chk1("t3_err_done", bus.o_err, 1'b0);
      bus.i_result_ack = 1'b1;
      tick();
      bus.i_result_ack = 1'b0;

      // Modulo wrap: 0xFFFFFFFF + 2 = 1
      bus.i_cfg_len    = 8'd2;
      bus.i_req0_valid = 1'b1;
      bus.i_req0_data  = 32'hFFFF_FFFF;
      tick();
      tick();
      bus.i_req0_data = 32'd2;
      tick();
      bus.i_req0_valid = 1'b0;
      tick();
      tick();
      chk("t4_wrap", bus.o_result, 32'd1);
      chk1("t4_src", bus.o_result_src, 1'b0);
      bus.i_result_ack = 1'b1;
      tick();
      bus.i_result_ack = 1'b0;

      // Accumulator returns 0x1234 in CAPT for burst {1,1}
      bus.i_req1_valid = 1'b1;
      bus.i_req1_data  = 32'd1;
      tick();
      tick();
      tick();
      bus.i_req1_valid = 1'b0;
      tick();
      force_en  = 1'b1;
      force_val = 32'h1234;
      tick();
      chk("t5_result", bus.o_result, 32'h1234);
      chk1("t5_src", bus.o_result_src, 1'b1);
      chk1("t5_intr", bus.o_intr, 1'b1);
      chk1("t5_err", bus.o_err, exp_chk_err);
      force_en = 1'b0;
      bus.i_result_ack = 1'b1;
      tick();
      bus.i_result_ack = 1'b0;

      // Zero length holds everything idle
      bus.i_cfg_len    = 8'd0;
      bus.i_req0_valid = 1'b1;
      bus.i_req1_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk1("t6_r0", bus.o_req0_ready, 1'b0);
         chk1("t6_r1", bus.o_req1_ready, 1'b0);
         chk1("t6_busy", bus.o_busy, 1'b0);
      end

      // Asynchronous reset mid-burst
      bus.i_cfg_len    = 8'd4;
      bus.i_req0_data  = 32'd3;
      bus.i_req1_valid = 1'b0;
      tick();
      tick();
      chk1("t7_pre_acc_valid", bus.o_acc_valid, 1'b1);
      #3;
      rst = 1'b0;
      #1;
      chk1("t7_acc_valid", bus.o_acc_valid, 1'b0);
      chk("t7_acc_data", bus.o_acc_data, 32'd0);
      chk1("t7_r0", bus.o_req0_ready, 1'b0);
      chk1("t7_busy", bus.o_busy, 1'b0);
      chk("t7_result", bus.o_result, 32'd0);
      chk1("t7_src", bus.o_result_src, 1'b0);
      chk1("t7_err", bus.o_err, 1'b0);
      chk("t7_state", 32'(bus.o_dbg_state), 32'd0);
      tick();
      rst = 1'b1;

      // After reset req0 wins a tie; len 1 burst
      bus.i_cfg_len    = 8'd1;
      bus.i_req0_data  = 32'h11;
      bus.i_req1_valid = 1'b1;
      bus.i_req1_data  = 32'h22;
      tick();
      chk1("t8_r0", bus.o_req0_ready, 1'b1);
      chk1("t8_r1", bus.o_req1_ready, 1'b0);
      tick();
      chk("t8_beat", bus.o_acc_data, 32'h11);
      chk1("t8_r0_closed", bus.o_req0_ready, 1'b0);
      bus.i_req0_valid = 1'b0;
      tick();
      tick();
      chk("t8_result", bus.o_result, 32'h11);
      chk1("t8_src", bus.o_result_src, 1'b0);
      chk1("t8_rvalid", bus.o_result_valid, 1'b1);
      bus.i_req1_valid = 1'b0;
      bus.i_result_ack = 1'b1;
      tick();
      bus.i_result_ack = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
